// File: rtl/led_cnt_pkg.sv
// led_cnt_pkg: mode encoding and terminal-count mask helper shared by the LED counter channels
package led_cnt_pkg;
   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_ONESHOT = 2'b11
   } mode_t;
   function automatic logic [63:0] tc_mask(input int unsigned div_eff, input int unsigned base_shift);
      return (64'd1 << (base_shift + div_eff)) - 64'd1;
   endfunction
endpackage

// File: rtl/led_cnt_chan.sv
// led_cnt_chan: one LED channel with programmable period and OFF/ON/BLINK/ONESHOT mode
module led_cnt_chan
   import led_cnt_pkg::*;
#(
   parameter int DIV_W = 5,
   parameter int BASE_SHIFT = 20,
   parameter int DIV_MAX = 7,
   parameter logic [1:0] RST_MODE = 2'b00,
   parameter int RST_DIV = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [DIV_W-1:0] div_i,
   input  logic [1:0]       mode_i,
   output logic             led_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam int CNT_W = BASE_SHIFT + DIV_MAX;
   localparam logic [DIV_W-1:0] DMAX = DIV_W'(DIV_MAX);
   mode_t            mode;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] mask;
   logic             tc;
   logic             fresh;
   always_comb begin
      mask = CNT_W'(tc_mask(32'(div), 32'(BASE_SHIFT)));
      tc = (cnt & mask) == mask;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mode   <= mode_t'(RST_MODE);
         div    <= DIV_W'(RST_DIV);
         cnt    <= '0;
         led_o  <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         fresh  <= 1'b1;
      end else begin
         done_o <= 1'b0;
         fresh  <= 1'b0;
         if (wr) begin
            mode   <= mode_t'(mode_i);
            div    <= (div_i > DMAX) ? DMAX : div_i;
            cnt    <= '0;
            led_o  <= mode_i != MODE_OFF;
            busy_o <= mode_i == MODE_ONESHOT;
         end else if (fresh) begin
            cnt    <= '0;
            led_o  <= mode != MODE_OFF;
            busy_o <= mode == MODE_ONESHOT;
         end else if (mode == MODE_BLINK || mode == MODE_ONESHOT) begin
            cnt <= tc ? '0 : cnt + 1'b1;
            if (tc && mode == MODE_ONESHOT) begin
               led_o  <= 1'b0;
               busy_o <= 1'b0;
               done_o <= 1'b1;
               mode   <= MODE_OFF;
            end else if (tc) begin
               led_o <= ~led_o;
            end
         end
      end
   end
endmodule

// File: rtl/led_cnt_multi.sv
// led_cnt_multi: NUM_LED independently programmable LED counter channels behind one write port
module led_cnt_multi
   import led_cnt_pkg::*;
#(
   parameter int NUM_LED = 4,
   parameter int DIV_W = 5,
   parameter int BASE_SHIFT = 20,
   parameter int DIV_MAX = 7,
   parameter int SEL_W = 4,
   parameter logic [1:0] RST_MODE = 2'b10,
   parameter int RST_DIV = 3
) (
   input  logic               clk100,
   input  logic               rst,
   input  logic [SEL_W-1:0]   ch_sel_i,
   input  logic [DIV_W-1:0]   div_i,
   input  logic [1:0]         mode_i,
   input  logic               wren_i,
   output logic [NUM_LED-1:0] led_o,
   output logic [NUM_LED-1:0] busy_o,
   output logic [NUM_LED-1:0] done_o
);
   logic [NUM_LED-1:0] we;
   for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
      assign we[i] = wren_i && (ch_sel_i == SEL_W'(i));
      led_cnt_chan #(
         .DIV_W(DIV_W),
         .BASE_SHIFT(BASE_SHIFT),
         .DIV_MAX(DIV_MAX),
         .RST_MODE((i == 0) ? RST_MODE : 2'(MODE_OFF)),
         .RST_DIV((i == 0) ? RST_DIV : 0)
      ) u_ch (
         .clk(clk100),
         .rst(rst),
         .wr(we[i]),
         .div_i(div_i),
         .mode_i(mode_i),
         .led_o(led_o[i]),
         .busy_o(busy_o[i]),
         .done_o(done_o[i])
      );
   end
endmodule

// File: tb/tb_led_cnt_multi.sv
// tb_led_cnt_multi: directed self-checking bench for led_cnt_multi with BASE_SHIFT=2
module tb_led_cnt_multi;
   logic       clk100 = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] ch_sel_i = '0;
   logic [4:0] div_i = '0;
   logic [1:0] mode_i = '0;
   logic       wren_i = 1'b0;
   logic [3:0] led_o, busy_o, done_o;
   int checks = 0;
   int errors = 0;

   led_cnt_multi #(
      .NUM_LED(4), .DIV_W(5), .BASE_SHIFT(2), .DIV_MAX(7), .SEL_W(4),
      .RST_MODE(2'b10), .RST_DIV(1)
   ) dut (
      .clk100(clk100), .rst(rst), .ch_sel_i(ch_sel_i), .div_i(div_i),
      .mode_i(mode_i), .wren_i(wren_i), .led_o(led_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk100 = ~clk100;

   task automatic tick(input int n);
      repeat (n) @(posedge clk100);
      #1;
   endtask

   task automatic wr(input logic [3:0] ch, input logic [4:0] dv, input logic [1:0] md);
      ch_sel_i = ch; div_i = dv; mode_i = md; wren_i = 1'b1;
      tick(1);
      wren_i = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tick(2);
      chk("rst_led", 16'(led_o), 16'h0);
      chk("rst_busy", 16'(busy_o), 16'h0);
      chk("rst_done", 16'(done_o), 16'h0);
      rst = 1'b0;
      tick(1);
      chk("rel_led_first", 16'(led_o), 16'h1);
      tick(7);
      chk("rel_led_hi_end", 16'(led_o), 16'h1);
      tick(1);
      chk("rel_led_low", 16'(led_o), 16'h0);
      tick(8);
      chk("rel_led_hi2", 16'(led_o), 16'h1);
      chk("rel_busy", 16'(busy_o), 16'h0);
      wr(4'd0, 5'd0, 2'b00);
      chk("ch0_off", 16'(led_o), 16'h0);

      wr(4'd1, 5'd0, 2'b10);
      chk("b1_w", 16'(led_o[1]), 16'h1);
      tick(3);
      chk("b1_hi_end", 16'(led_o[1]), 16'h1);
      tick(1);
      chk("b1_low", 16'(led_o[1]), 16'h0);
      tick(3);
      chk("b1_low_end", 16'(led_o[1]), 16'h0);
      tick(1);
      chk("b1_hi2", 16'(led_o[1]), 16'h1);
      tick(2);
      wr(4'd1, 5'd2, 2'b10);
      chk("b16_w", 16'(led_o[1]), 16'h1);
      tick(15);
      chk("b16_hi_end", 16'(led_o[1]), 16'h1);
      tick(1);
      chk("b16_low", 16'(led_o[1]), 16'h0);
      tick(15);
      chk("b16_low_end", 16'(led_o[1]), 16'h0);
      tick(1);
      chk("b16_hi2", 16'(led_o[1]), 16'h1);

      wr(4'd3, 5'd0, 2'b01);
      chk("ch3_on", 16'(led_o), 16'hA);
      tick(14);
      chk("ch1_phase_hi", 16'(led_o[1]), 16'h1);
      tick(1);
      chk("ch1_phase_low", 16'(led_o), 16'h8);
      wr(4'd1, 5'd0, 2'b00);
      wr(4'd3, 5'd0, 2'b00);
      chk("all_off", 16'(led_o), 16'h0);

      wr(4'd2, 5'd1, 2'b11);
      chk("os_led", 16'(led_o), 16'h4);
      chk("os_busy", 16'(busy_o), 16'h4);
      chk("os_done0", 16'(done_o), 16'h0);
      tick(7);
      chk("os_led_end", 16'(led_o), 16'h4);
      chk("os_done_early", 16'(done_o), 16'h0);
      tick(1);
      chk("os_led_off", 16'(led_o), 16'h0);
      chk("os_busy_off", 16'(busy_o), 16'h0);
      chk("os_done", 16'(done_o), 16'h4);
      tick(1);
      chk("os_done_1cyc", 16'(done_o), 16'h0);
      tick(10);
      chk("os_idle_led", 16'(led_o), 16'h0);
      chk("os_idle_done", 16'(done_o), 16'h0);

      wr(4'd2, 5'd1, 2'b11);
      tick(7);
      wr(4'd2, 5'd0, 2'b00);
      chk("col_led", 16'(led_o), 16'h0);
      chk("col_busy", 16'(busy_o), 16'h0);
      chk("col_done", 16'(done_o), 16'h0);
      tick(1);
      chk("col_done_next", 16'(done_o), 16'h0);

      wr(4'd1, 5'd31, 2'b10);
      tick(511);
      chk("clamp_hi_end", 16'(led_o), 16'h2);
      tick(1);
      chk("clamp_low", 16'(led_o), 16'h0);
      wr(4'd1, 5'd0, 2'b00);

      wr(4'd5, 5'd0, 2'b11);
      chk("bad_sel_led", 16'(led_o), 16'h0);
      chk("bad_sel_busy", 16'(busy_o), 16'h0);
      tick(10);
      chk("bad_sel_later", 16'(led_o), 16'h0);

      wr(4'd2, 5'd1, 2'b11);
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_led", 16'(led_o), 16'h0);
      chk("mid_rst_busy", 16'(busy_o), 16'h0);
      chk("mid_rst_done", 16'(done_o), 16'h0);
      rst = 1'b0;
      tick(1);
      chk("post_rst_led", 16'(led_o), 16'h1);
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_done", 16'(done_o), 16'h0);
         tick(1);
      end
      chk("post_rst_busy", 16'(busy_o), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
